// File: rtl/core_pkg.sv
// Shared core-side memory interface types: responder state encoding, request
// record used by both core_mem and core_l1d_resp, and the timeout error word.
package core_pkg;

    typedef enum logic [2:0] {
        L1D_IDLE,
        L1D_LOCAL,
        L1D_EXT_REQ,
        L1D_EXT_WAIT,
        L1D_DRAIN
    } l1d_state_e;

    localparam logic [31:0] L1D_ERR_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        we;
        logic        cacheable;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } l1d_req_t;

endpackage

// File: rtl/core_l1d_sram.sv
// Local data SRAM: 2^AW x 32b single port, byte-masked write, registered read.
// Contents are deliberately not reset.
module core_l1d_sram
    import core_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [2**AW];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (en && !we) rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/core_l1d_resp.sv
// Core data-memory responder: steers one request at a time to the local SRAM
// (cacheable) or the external bus (uncacheable, with response timeout).
module core_l1d_resp
    import core_pkg::*;
#(
    parameter int LOCAL_AW = 10,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        l1d_req_val,
    output logic        l1d_req_ack,
    input  logic        l1d_req_we,
    input  logic        l1d_req_cacheable,
    input  logic [31:0] l1d_req_addr,
    input  logic [3:0]  l1d_req_be,
    input  logic [31:0] l1d_req_wdata,
    input  logic        l1d_kill,
    output logic        l1d_ack_val,
    output logic [31:0] l1d_ack_rdata,
    output logic        l1d_ack_err,
    output logic        ext_req_val,
    input  logic        ext_req_rdy,
    output logic        ext_req_we,
    output logic [31:0] ext_req_addr,
    output logic [3:0]  ext_req_be,
    output logic [31:0] ext_req_wdata,
    input  logic        ext_rsp_val,
    input  logic [31:0] ext_rsp_rdata
);

    localparam logic [15:0] TMO_CNT = 16'(TIMEOUT);

    l1d_state_e  state_q, state_d;
    l1d_req_t    req_q, req_d;
    logic [15:0] cnt_q, cnt_d;
    logic        kill_q, kill_d;
    logic        ext_done_q, ext_done_d;
    logic        ext_err_q, ext_err_d;
    logic [31:0] ext_rdata_q, ext_rdata_d;
    logic [31:0] hold_rdata_q, hold_rdata_d;
    logic        hold_err_q, hold_err_d;
    logic [31:0] sram_rdata;
    logic        hs, timeout, local_fire, ext_fire;
    logic        unused_req;

    assign l1d_req_ack = (state_q == L1D_IDLE) & ~l1d_kill & ~rst;
    assign hs          = l1d_req_val & l1d_req_ack;
    assign timeout     = (state_q == L1D_EXT_WAIT) & (cnt_q == TMO_CNT);

    // SRAM is driven straight from the request port so a load's word is ready in LOCAL.
    core_l1d_sram #(.AW(LOCAL_AW)) u_sram (
        .clk   (clk),
        .en    (hs & l1d_req_cacheable),
        .we    (l1d_req_we),
        .be    (l1d_req_be),
        .addr  (l1d_req_addr[LOCAL_AW+1:2]),
        .wdata (l1d_req_wdata),
        .rdata (sram_rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            L1D_IDLE:     if (hs) state_d = l1d_req_cacheable ? L1D_LOCAL : L1D_EXT_REQ;
            L1D_LOCAL:    state_d = L1D_IDLE;
            L1D_EXT_REQ:  if (ext_req_rdy) state_d = L1D_EXT_WAIT;
            L1D_EXT_WAIT: if (ext_rsp_val) state_d = L1D_IDLE;
                          else if (timeout) state_d = L1D_DRAIN;
            L1D_DRAIN:    if (ext_rsp_val) state_d = L1D_IDLE;
            default:      state_d = L1D_IDLE;
        endcase

        req_d = req_q;
        if (hs) req_d = '{we: l1d_req_we, cacheable: l1d_req_cacheable, addr: l1d_req_addr,
                          be: l1d_req_be, wdata: l1d_req_wdata};

        cnt_d  = (state_q == L1D_EXT_WAIT) ? cnt_q + 16'd1 : 16'd0;
        kill_d = (state_q != L1D_IDLE) & (kill_q | l1d_kill);

        // Response beats timeout when both land in the same cycle.
        ext_done_d  = (state_q == L1D_EXT_WAIT) & (ext_rsp_val | timeout) & ~kill_q & ~l1d_kill;
        ext_err_d   = ~ext_rsp_val;
        ext_rdata_d = ext_rsp_val ? (req_q.we ? 32'd0 : ext_rsp_rdata) : L1D_ERR_DATA;

        hold_rdata_d = l1d_ack_val ? l1d_ack_rdata : hold_rdata_q;
        hold_err_d   = l1d_ack_val ? l1d_ack_err : hold_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= L1D_IDLE;
            req_q        <= '0;
            cnt_q        <= '0;
            kill_q       <= 1'b0;
            ext_done_q   <= 1'b0;
            ext_err_q    <= 1'b0;
            ext_rdata_q  <= '0;
            hold_rdata_q <= '0;
            hold_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            kill_q       <= kill_d;
            ext_done_q   <= ext_done_d;
            ext_err_q    <= ext_err_d;
            ext_rdata_q  <= ext_rdata_d;
            hold_rdata_q <= hold_rdata_d;
            hold_err_q   <= hold_err_d;
        end
    end

    // A kill arriving in the completion cycle itself still swallows the pulse.
    assign local_fire = (state_q == L1D_LOCAL) & ~kill_q & ~l1d_kill;
    assign ext_fire   = ext_done_q & ~l1d_kill;

    assign l1d_ack_val   = ~rst & (local_fire | ext_fire);
    assign l1d_ack_rdata = rst        ? 32'd0 :
                           local_fire ? (req_q.we ? 32'd0 : sram_rdata) :
                           ext_fire   ? ext_rdata_q : hold_rdata_q;
    assign l1d_ack_err   = ~rst & (local_fire ? 1'b0 : ext_fire ? ext_err_q : hold_err_q);

    assign ext_req_val   = ~rst & (state_q == L1D_EXT_REQ);
    assign ext_req_we    = ext_req_val & req_q.we;
    assign ext_req_addr  = ext_req_val ? {req_q.addr[31:2], 2'b00} : 32'd0;
    assign ext_req_be    = ext_req_val ? req_q.be : 4'd0;
    assign ext_req_wdata = ext_req_val ? req_q.wdata : 32'd0;

    assign unused_req = ^{req_q.cacheable, req_q.addr[1:0]};

    a_rsp_proto: assert property (@(posedge clk) disable iff (rst)
        !(ext_rsp_val && (state_q inside {L1D_IDLE, L1D_LOCAL, L1D_EXT_REQ})));

endmodule

// File: tb/tb_core_l1d_resp.sv
// Directed + randomized bench for core_l1d_resp against a word-array memory
// model and a per-transaction timing model of the external path.
module tb_core_l1d_resp;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        l1d_req_val, l1d_req_ack, l1d_req_we, l1d_req_cacheable;
    logic [31:0] l1d_req_addr, l1d_req_wdata;
    logic [3:0]  l1d_req_be;
    logic        l1d_kill, l1d_ack_val, l1d_ack_err;
    logic [31:0] l1d_ack_rdata;
    logic        ext_req_val, ext_req_rdy, ext_req_we;
    logic [31:0] ext_req_addr, ext_req_wdata;
    logic [3:0]  ext_req_be;
    logic        ext_rsp_val;
    logic [31:0] ext_rsp_rdata;

    always #5 clk = ~clk;

    core_l1d_resp #(.LOCAL_AW(10), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .l1d_req_val(l1d_req_val), .l1d_req_ack(l1d_req_ack), .l1d_req_we(l1d_req_we),
        .l1d_req_cacheable(l1d_req_cacheable), .l1d_req_addr(l1d_req_addr),
        .l1d_req_be(l1d_req_be), .l1d_req_wdata(l1d_req_wdata), .l1d_kill(l1d_kill),
        .l1d_ack_val(l1d_ack_val), .l1d_ack_rdata(l1d_ack_rdata), .l1d_ack_err(l1d_ack_err),
        .ext_req_val(ext_req_val), .ext_req_rdy(ext_req_rdy), .ext_req_we(ext_req_we),
        .ext_req_addr(ext_req_addr), .ext_req_be(ext_req_be), .ext_req_wdata(ext_req_wdata),
        .ext_rsp_val(ext_rsp_val), .ext_rsp_rdata(ext_rsp_rdata)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mem_m [1024];
    logic [31:0] last_rdata;
    logic        last_err;
    logic [9:0]  idxs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet_outputs(input string tag);
        chk({tag, "_req_ack"}, l1d_req_ack, 0);
        chk({tag, "_ack_val"}, l1d_ack_val, 0);
        chk({tag, "_ack_rdata"}, l1d_ack_rdata, 0);
        chk({tag, "_ack_err"}, l1d_ack_err, 0);
        chk({tag, "_ext_val"}, ext_req_val, 0);
        chk({tag, "_ext_fields"}, {ext_req_we, ext_req_be, ext_req_addr[26:0]}, 0);
        chk({tag, "_ext_wdata"}, ext_req_wdata, 0);
    endtask

    task automatic drive_req(input logic we, input logic cacheable, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata);
        l1d_req_val = 1'b1; l1d_req_we = we; l1d_req_cacheable = cacheable;
        l1d_req_addr = addr; l1d_req_be = be; l1d_req_wdata = wdata;
    endtask

    // Scramble request fields after acceptance so uncaptured use shows up.
    task automatic drop_req();
        l1d_req_val = 1'b0; l1d_req_we = $urandom; l1d_req_cacheable = $urandom;
        l1d_req_addr = $urandom; l1d_req_be = $urandom; l1d_req_wdata = $urandom;
    endtask

    task automatic local_op(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic kill);
        int          idx;
        logic [31:0] exp;
        idx = int'(addr[11:2]);
        drive_req(we, 1'b1, addr, be, wdata);
        #1;
        chk("loc_accept", l1d_req_ack, 1);
        chk("loc_idle_ackval", l1d_ack_val, 0);
        chk("loc_hold_rdata", l1d_ack_rdata, last_rdata);
        chk("loc_hold_err", l1d_ack_err, last_err);
        tick();
        drop_req();
        l1d_kill = kill;
        exp = we ? 32'd0 : mem_m[idx];
        if (we) for (int b = 0; b < 4; b++) if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
        #1;
        chk("loc_ackval", l1d_ack_val, !kill);
        chk("loc_busy", l1d_req_ack, 0);
        if (!kill) begin
            chk("loc_rdata", l1d_ack_rdata, exp);
            chk("loc_err", l1d_ack_err, 0);
            last_rdata = exp;
            last_err   = 1'b0;
        end
        tick();
        l1d_kill = 1'b0;
    endtask

    // rsp_dly/kill_at count cycles from the first cycle after the bus handshake.
    task automatic ext_op(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input int rdy_dly, input int rsp_dly,
                          input logic [31:0] rsp_data, input int kill_at);
        int          done_w;
        bit          tmo, killed;
        logic [31:0] exp_rd;
        tmo    = rsp_dly > TMO;
        done_w = tmo ? TMO : rsp_dly;
        killed = (kill_at >= 0) && (kill_at <= done_w + 1);
        exp_rd = tmo ? 32'hDEAD_BEEF : (we ? 32'd0 : rsp_data);

        drive_req(we, 1'b0, addr, be, wdata);
        #1;
        chk("ext_accept", l1d_req_ack, 1);
        chk("ext_idle_ackval", l1d_ack_val, 0);
        chk("ext_hold_rdata", l1d_ack_rdata, last_rdata);
        tick();
        drop_req();
        for (int i = 0; i <= rdy_dly; i++) begin
            ext_req_rdy = (i == rdy_dly);
            #1;
            chk("ext_req_val", ext_req_val, 1);
            chk("ext_req_addr", ext_req_addr, {addr[31:2], 2'b00});
            chk("ext_req_ctl", {ext_req_we, ext_req_be}, {we, be});
            chk("ext_req_wdata", ext_req_wdata, wdata);
            chk("ext_req_busy", l1d_req_ack, 0);
            tick();
        end
        ext_req_rdy = 1'b0;
        for (int w = 0; w <= done_w; w++) begin
            ext_rsp_val   = (w == rsp_dly);
            ext_rsp_rdata = (w == rsp_dly) ? rsp_data : $urandom;
            l1d_kill      = (w == kill_at);
            #1;
            chk("ext_wait_val", ext_req_val, 0);
            chk("ext_wait_ackval", l1d_ack_val, 0);
            chk("ext_wait_busy", l1d_req_ack, 0);
            tick();
        end
        ext_rsp_val = 1'b0;
        l1d_kill    = (kill_at == done_w + 1);
        #1;
        chk("ext_done_ackval", l1d_ack_val, !killed);
        chk("ext_done_reqack", l1d_req_ack, !tmo && (kill_at != done_w + 1));
        if (!killed) begin
            chk("ext_done_rdata", l1d_ack_rdata, exp_rd);
            chk("ext_done_err", l1d_ack_err, tmo);
            last_rdata = exp_rd;
            last_err   = tmo;
        end
        tick();
        l1d_kill = 1'b0;
        if (tmo) begin
            for (int w = done_w + 2; w <= rsp_dly; w++) begin
                ext_rsp_val   = (w == rsp_dly);
                ext_rsp_rdata = $urandom;
                #1;
                chk("drain_ackval", l1d_ack_val, 0);
                chk("drain_busy", l1d_req_ack, 0);
                chk("drain_hold", {l1d_ack_err, l1d_ack_rdata[30:0]}, {last_err, last_rdata[30:0]});
                tick();
            end
            ext_rsp_val = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a;
        int          rsp_d, kill_d;
        rst = 1'b1; l1d_kill = 1'b0; ext_req_rdy = 1'b0; ext_rsp_val = 1'b0;
        ext_rsp_rdata = '0;
        drop_req();
        last_rdata = '0; last_err = 1'b0;
        repeat (3) tick();
        #1;
        chk_quiet_outputs("reset");
        rst = 1'b0;
        #1;
        chk("post_reset_ack", l1d_req_ack, 1);
        tick();

        // Byte-masked store into a cleared word, then read back.
        local_op(1'b1, 32'h40, 4'hF, 32'h0, 1'b0);
        local_op(1'b1, 32'h40, 4'b0011, 32'h1122_3344, 1'b0);
        local_op(1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
        #1;
        chk("spec_load_rdata", l1d_ack_rdata, 32'h0000_3344);
        tick();

        for (int k = 0; k < 8; k++) begin
            idxs[k] = 10'(k * 97 + 3);
            a = $urandom; a[11:2] = idxs[k];
            local_op(1'b1, a, 4'hF, $urandom, 1'b0);
        end
        for (int n = 0; n < 40; n++) begin
            a = $urandom; a[11:2] = idxs[$urandom_range(0, 7)];
            local_op(1'(($urandom_range(0, 2)) == 0), a, 4'($urandom), $urandom,
                     1'($urandom_range(0, 7) == 0));
        end

        ext_op(1'b0, 32'h8000_0000, 4'hF, 32'h0, 3, 4, 32'hCAFE_F00D, -1);
        ext_op(1'b0, 32'h8000_0104, 4'hF, 32'h0, 0, TMO, 32'h1234_5678, -1);
        ext_op(1'b0, 32'h8000_0203, 4'hF, 32'h0, 1, 0, 32'hA5A5_5A5A, -1);
        ext_op(1'b1, 32'h9000_0010, 4'b1010, 32'h7777_8888, 2, 2, 32'hFFFF_FFFF, -1);
        ext_op(1'b0, 32'hC000_0000, 4'hF, 32'h0, 0, 20, 32'h0BAD_0BAD, -1);
        ext_op(1'b0, 32'hC000_0040, 4'hF, 32'h0, 0, 5, 32'h0DDB_A11, 2);

        // Kill a local store in its completion cycle; the write still lands.
        local_op(1'b1, 32'h0000_0200, 4'hF, 32'h5555_AAAA, 1'b1);
        local_op(1'b0, 32'h0000_0200, 4'h0, 32'h0, 1'b0);
        #1;
        chk("kill_store_kept", l1d_ack_rdata, 32'h5555_AAAA);
        tick();

        for (int n = 0; n < 14; n++) begin
            rsp_d  = ($urandom_range(0, 5) == 0) ? $urandom_range(TMO + 2, TMO + 8)
                                                 : $urandom_range(0, TMO);
            kill_d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (rsp_d > TMO ? TMO : rsp_d) + 1) : -1;
            ext_op(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom_range(0, 3),
                   rsp_d, $urandom, kill_d);
        end

        // Reset while the bus request is outstanding.
        drive_req(1'b0, 1'b0, 32'h8000_0800, 4'hF, 32'h0);
        #1;
        chk("rst_accept", l1d_req_ack, 1);
        tick();
        drop_req();
        #1;
        chk("rst_in_extreq", ext_req_val, 1);
        tick();
        rst = 1'b1;
        #1;
        chk_quiet_outputs("mid_rst");
        tick();
        rst = 1'b0;
        last_rdata = '0; last_err = 1'b0;
        #1;
        chk("after_rst_extval", ext_req_val, 0);
        chk("after_rst_ackval", l1d_ack_val, 0);
        chk("after_rst_reqack", l1d_req_ack, 1);
        tick();
        ext_op(1'b0, 32'h8000_0800, 4'hF, 32'h0, 1, 3, 32'h600D_DA7A, -1);
        local_op(1'b0, 32'h0000_0200, 4'h0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
